// File: rtl/or_and_pipe_pkg.sv
// Shared types, mode encodings and bitwise helpers for the or_and_pipe block.
// Operands are carried in a 64-bit container, so WIDTH is limited to 64.
package or_and_pkg;

    localparam int unsigned OP_MAX_W = 64;

    typedef logic [1:0]          mode_t;
    typedef logic [OP_MAX_W-1:0] op_t;

    localparam mode_t MODE_OR_AND  = 2'd0;
    localparam mode_t MODE_AND_OR  = 2'd1;
    localparam mode_t MODE_XOR_AND = 2'd2;
    localparam mode_t MODE_NOR_AND = 2'd3;

    function automatic op_t or_and_op1(input op_t a, input op_t b, input mode_t mode);
        op_t t;
        case (mode)
            MODE_OR_AND:  t = a | b;
            MODE_AND_OR:  t = a & b;
            MODE_XOR_AND: t = a ^ b;
            MODE_NOR_AND: t = a | b;
            default:      t = a | b;
        endcase
        return t;
    endfunction

    // The mode 3 inversion lands in the second level, after the AND with c.
    function automatic op_t or_and_op2(input op_t t, input op_t c, input mode_t mode);
        op_t x;
        case (mode)
            MODE_OR_AND:  x = t & c;
            MODE_AND_OR:  x = t | c;
            MODE_XOR_AND: x = t & c;
            MODE_NOR_AND: x = ~(t & c);
            default:      x = t & c;
        endcase
        return x;
    endfunction

    function automatic op_t or_and_apply(input op_t a, input op_t b, input op_t c, input mode_t mode);
        return or_and_op2(or_and_op1(a, b, mode), c, mode);
    endfunction

    function automatic logic or_and_parity(input op_t v);
        return ^v;
    endfunction

endpackage

// File: rtl/or_and_pipe_stage.sv
// Valid/ready register slice: loads whenever empty or the downstream side accepts.
module pipe_stage #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic              load_s;

    assign load_s    = !valid_r || out_ready;
    assign in_ready  = load_s;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slice register; data follows valid on every load so bubbles carry don't-care data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else if (load_s) begin
            valid_r <= in_valid;
            data_r  <= in_data;
        end
    end

endmodule

// File: rtl/or_and_pipe.sv
// Two-stage valid/ready pipeline applying a selectable two-level bitwise function.
// Define OR_AND_PARITY_EN to add the registered out_parity output (^out_x).
module or_and_pipe
    import or_and_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [CNT_W-1:0] out_count
`ifdef OR_AND_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam int unsigned S1_W = 2 + 2 * WIDTH;
`ifdef OR_AND_PARITY_EN
    localparam int unsigned S2_W = WIDTH + 1;
`else
    localparam int unsigned S2_W = WIDTH;
`endif

    logic [WIDTH-1:0] t1_next_s;
    logic [S1_W-1:0]  s1_in_s;
    logic [S1_W-1:0]  s1_data_s;
    logic             s1_valid_s;
    logic             adv2_s;
    logic [WIDTH-1:0] t1_s;
    logic [WIDTH-1:0] c1_s;
    mode_t            mode1_s;
    logic [WIDTH-1:0] x2_next_s;
    logic [S2_W-1:0]  s2_in_s;
    logic [S2_W-1:0]  s2_data_s;
    logic [CNT_W-1:0] count_r;

    assign t1_next_s = WIDTH'(or_and_op1(op_t'(in_a), op_t'(in_b), in_mode));
    assign s1_in_s   = {in_mode, in_c, t1_next_s};

    pipe_stage #(.DATA_W(S1_W)) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in_s),
        .out_valid (s1_valid_s),
        .out_ready (adv2_s),
        .out_data  (s1_data_s)
    );

    assign t1_s      = s1_data_s[WIDTH-1:0];
    assign c1_s      = s1_data_s[2*WIDTH-1:WIDTH];
    assign mode1_s   = s1_data_s[2*WIDTH+1:2*WIDTH];
    // Truncate before parity so the mode 3 inversion of unused upper bits cannot leak in.
    assign x2_next_s = WIDTH'(or_and_op2(op_t'(t1_s), op_t'(c1_s), mode1_s));

`ifdef OR_AND_PARITY_EN
    assign s2_in_s   = {or_and_parity(op_t'(x2_next_s)), x2_next_s};
`else
    assign s2_in_s   = x2_next_s;
`endif

    pipe_stage #(.DATA_W(S2_W)) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid_s),
        .in_ready  (adv2_s),
        .in_data   (s2_in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data_s)
    );

    assign out_x = s2_data_s[WIDTH-1:0];
`ifdef OR_AND_PARITY_EN
    assign out_parity = s2_data_s[WIDTH];
`endif

    // Delivered-result counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (out_valid && out_ready) begin
            count_r <= count_r + CNT_W'(1'b1);
        end
    end

    assign out_count = count_r;

endmodule

// File: tb/tb_or_and_pipe.sv
// Directed and randomised checks of or_and_pipe (WIDTH=8, CNT_W=4 to exercise wrap).
module tb_or_and_pipe;
    import or_and_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] in_c;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_x;
    logic [3:0] out_count;
`ifdef OR_AND_PARITY_EN
    logic       out_parity;
`endif

    int checks = 0;
    int fails  = 0;

    or_and_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_count (out_count)
`ifdef OR_AND_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [1:0] m, input logic rdy);
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_c      = c;
        in_mode   = m;
        out_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_x !== 8'h00) begin fails++; $display("FAIL reset_x: got %h expected 00", out_x); end
        checks++; if (out_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", out_count); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single();
        drive(1'b1, 8'h0F, 8'hF0, 8'h3C, 2'd0, 1'b1);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b expected 1", in_ready); end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_early: got %b expected 0", out_valid); end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (out_x !== 8'h3C) begin fails++; $display("FAIL single_x: got %h expected 3c", out_x); end
        checks++; if (out_count !== 4'd0) begin fails++; $display("FAIL single_cnt0: got %0d expected 0", out_count); end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain: got %b expected 0", out_valid); end
        checks++; if (out_count !== 4'd1) begin fails++; $display("FAIL single_cnt1: got %0d expected 1", out_count); end
    endtask

    task automatic test_modes();
        logic [7:0] exp_x [3];
        logic [1:0] mv [3];
        exp_x = '{8'h8F, 8'h06, 8'hF1};
        mv    = '{2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, 8'hAA, 8'hCC, 8'h0F, mv[i], 1'b1);
            else       drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
            checks++; if (out_valid !== (i >= 2)) begin fails++; $display("FAIL modes_valid[%0d]: got %b expected %b", i, out_valid, (i >= 2)); end
            if (i >= 2) begin
                checks++; if (out_x !== exp_x[i-2]) begin fails++; $display("FAIL modes_x[%0d]: got %h expected %h", i - 2, out_x, exp_x[i-2]); end
            end
        end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        checks++; if (out_count !== 4'd4) begin fails++; $display("FAIL modes_cnt: got %0d expected 4", out_count); end
    endtask

    task automatic test_stall();
        drive(1'b1, 8'h01, 8'h02, 8'hFF, 2'd0, 1'b0);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_rdy0: got %b expected 1", in_ready); end
        drive(1'b1, 8'hF0, 8'h30, 8'h01, 2'd1, 1'b0);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_rdy1: got %b expected 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h55, 8'hFF, 8'hF0, 2'd2, 1'b0);
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_full[%0d]: got %b expected 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_x !== 8'h03) begin fails++; $display("FAIL stall_hold[%0d]: got %b/%h expected 1/03", i, out_valid, out_x); end
`ifdef OR_AND_PARITY_EN
            checks++; if (out_parity !== 1'b0) begin fails++; $display("FAIL stall_par[%0d]: got %b expected 0", i, out_parity); end
`endif
        end
        // Full pipe, both transfers in the same cycle.
        drive(1'b1, 8'h55, 8'hFF, 8'hF0, 2'd2, 1'b1);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_release: got %b expected 1", in_ready); end
        checks++; if (out_x !== 8'h03) begin fails++; $display("FAIL stall_x0: got %h expected 03", out_x); end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_x !== 8'h31) begin fails++; $display("FAIL stall_x1: got %b/%h expected 1/31", out_valid, out_x); end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_x !== 8'hA0) begin fails++; $display("FAIL stall_x2: got %b/%h expected 1/a0", out_valid, out_x); end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_dup: got %b expected 0", out_valid); end
        checks++; if (out_count !== 4'd7) begin fails++; $display("FAIL stall_cnt: got %0d expected 7", out_count); end
    endtask

`ifdef OR_AND_PARITY_EN
    task automatic test_parity();
        drive(1'b1, 8'h07, 8'h00, 8'hFF, 2'd0, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        checks++; if (out_x !== 8'h07 || out_parity !== 1'b1) begin fails++; $display("FAIL parity_07: got %h/%b expected 07/1", out_x, out_parity); end
    endtask
`endif

    task automatic test_inflight_reset();
        drive(1'b1, 8'h11, 8'h22, 8'hFF, 2'd0, 1'b0);
        drive(1'b1, 8'h44, 8'h88, 8'hFF, 2'd0, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_x !== 8'h33) begin fails++; $display("FAIL rst_pre: got %b/%h expected 1/33", out_valid, out_x); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        checks++; if (out_x !== 8'h00) begin fails++; $display("FAIL rst_x: got %h expected 00", out_x); end
        checks++; if (out_count !== 4'd0) begin fails++; $display("FAIL rst_count: got %0d expected 0", out_count); end
`ifdef OR_AND_PARITY_EN
        checks++; if (out_parity !== 1'b0) begin fails++; $display("FAIL rst_par: got %b expected 0", out_parity); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
            checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_stale[%0d]: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_wrap();
        int         n;
        logic [7:0] jb;
        logic [3:0] exp_cnt;
        for (int j = 0; j < 20; j++) begin
            jb = 8'(j);
            drive(j < 17, jb, 8'h00, 8'hFF, 2'd0, 1'b1);
            n = (j < 2) ? 0 : ((j - 2 > 17) ? 17 : j - 2);
            exp_cnt = n[3:0];
            checks++; if (out_count !== exp_cnt) begin fails++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", j, out_count, exp_cnt); end
            if (j >= 2 && j < 19) begin
                jb = 8'(j - 2);
                checks++; if (out_valid !== 1'b1 || out_x !== jb) begin fails++; $display("FAIL wrap_x[%0d]: got %b/%h expected 1/%h", j, out_valid, out_x, jb); end
            end
        end
        checks++; if (out_count !== 4'd1) begin fails++; $display("FAIL wrap_final: got %0d expected 1", out_count); end
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] a, b, c, exp_x;
        logic [1:0] m;
        logic       v, r;
        op_t        full;
        int         sent, got, cycles;
        int         base;
        logic [3:0] exp_cnt;
        sent = 0; got = 0; cycles = 0;
        base = 1;
        while (got < 1000 && cycles < 20000) begin
            v = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            c = 8'($urandom_range(0, 255));
            m = 2'($urandom_range(0, 3));
            r = 1'($urandom_range(0, 1));
            drive(v, a, b, c, m, r);
            cycles++;
            checks++; if (in_ready !== ((q.size() < 2) || r)) begin fails++; $display("FAIL rand_ready@%0d: got %b expected %b", cycles, in_ready, ((q.size() < 2) || r)); end
            exp_cnt = 4'(base + got);
            checks++; if (out_count !== exp_cnt) begin fails++; $display("FAIL rand_cnt@%0d: got %0d expected %0d", cycles, out_count, exp_cnt); end
            if (out_valid === 1'b1 && r) begin
                checks++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rand_dup@%0d: got result %h expected none", cycles, out_x);
                end else begin
                    exp_x = q.pop_front();
                    if (out_x !== exp_x) begin fails++; $display("FAIL rand_x@%0d: got %h expected %h", cycles, out_x, exp_x); end
                end
                got++;
            end
            if (v && in_ready === 1'b1) begin
                full = or_and_apply(op_t'(a), op_t'(b), op_t'(c), m);
                q.push_back(full[7:0]);
                sent++;
            end
        end
        checks++; if (got != 1000 || q.size() != 0) begin fails++; $display("FAIL rand_total: got %0d delivered, %0d pending expected 1000, 0", got, q.size()); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
            checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rand_extra[%0d]: got %b expected 0", i, out_valid); end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_c = 8'h00;
        in_mode = 2'd0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_modes();
        test_stall();
`ifdef OR_AND_PARITY_EN
        test_parity();
`endif
        test_inflight_reset();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
